// File: rtl/stream_buf.sv
// Purpose : single-clock stream FIFO that applies a MODE transform to each word as it is stored.
// Latency : 1 cycle from push to valid_o/data_o when empty; no same-cycle bypass.
// Backpres: ready_o=0 while full; a pop in the full cycle frees the slot for the next cycle only.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-high reset
//   valid_i/ready_o   upstream handshake, data_i upstream payload
//   valid_o/ready_i   downstream handshake, data_o oldest entry (zero when empty)
//   flush_i           synchronous discard of all stored entries
//   level_o           occupancy 0..DEPTH
// Optional feature macro STREAM_BUF_STATS_EN adds in_cnt_o/out_cnt_o
// (16-bit push/pop counters, wrapping, cleared by reset only).
module stream_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int MODE   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DATA_W-1:0]      data_o,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] level_o
`ifdef STREAM_BUF_STATS_EN
    ,
    output logic [15:0]            in_cnt_o,
    output logic [15:0]            out_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic [DATA_W-1:0] xf_data;
    logic              push;
    logic              pop;

    // Handshake outputs come from the registered level only, so there is
    // no combinational path from valid_i or ready_i.
    assign ready_o = (level < LW'(DEPTH));
    assign valid_o = (level != '0);
    assign level_o = level;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

    // A flush cycle discards any push or pop presented alongside it.
    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_o & ready_i & ~flush_i;

    always_comb begin
        xf_data = data_i;
        case (MODE)
            1:       xf_data = ~data_i;
            2:       xf_data = data_i + DATA_W'(1);
            default: xf_data = data_i;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally at DEPTH-1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; an empty level masks stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= xf_data;
    end

`ifdef STREAM_BUF_STATS_EN
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            in_cnt_o  <= '0;
            out_cnt_o <= '0;
        end else begin
            if (push) in_cnt_o  <= in_cnt_o + 16'd1;
            if (pop)  out_cnt_o <= out_cnt_o + 16'd1;
        end
    end
`endif

endmodule
